// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core sequencer.
// Contents: sequencer state enum, stage index constants, default reset PC.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StF,
    StFW,
    StD,
    StDW,
    StE,
    StEW,
    StM,
    StMW,
    StW,
    StWW,
    StHalt
  } ctrl_state_t;

  localparam int unsigned NUM_STG = 5;

  // Stage indices into the packed enable/done vectors.
  localparam logic [2:0] STG_F = 3'd0;
  localparam logic [2:0] STG_D = 3'd1;
  localparam logic [2:0] STG_E = 3'd2;
  localparam logic [2:0] STG_M = 3'd3;
  localparam logic [2:0] STG_W = 3'd4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

endpackage

// File: rtl/core_ctrl_if.sv
// Stage handshake bundle between the sequencer and the five pipeline stages.
// master: sequencer side (drives *_en, receives *_done and the jump result).
// slave:  stage side (receives *_en, drives *_done and the jump result).
interface core_ctrl_if #(
  parameter int unsigned PC_W = 32
) ();

  logic            fetch_en;
  logic            decode_en;
  logic            exec_en;
  logic            mem_en;
  logic            wb_en;
  logic            fetch_done;
  logic            decode_done;
  logic            exec_done;
  logic            mem_done;
  logic            wb_done;
  logic            is_jump;
  logic [PC_W-1:0] jump_dest;

  modport master (
    output fetch_en, decode_en, exec_en, mem_en, wb_en,
    input  fetch_done, decode_done, exec_done, mem_done, wb_done,
    input  is_jump, jump_dest
  );

  modport slave (
    input  fetch_en, decode_en, exec_en, mem_en, wb_en,
    output fetch_done, decode_done, exec_done, mem_done, wb_done,
    output is_jump, jump_dest
  );

endinterface

// File: rtl/core_ctrl.sv
// Multi-cycle core sequencer. Pulses each stage enable for one cycle in order
// F, D, E, M, W, waiting for that stage's done before moving on. Owns the
// word-indexed PC and applies the execute stage's jump result at retirement.
//
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   start          begin execution from RESET_PC (only honoured in IDLE)
//   halt_req       stop at the next instruction boundary (sticky)
//   stg            stage handshake bundle (core_ctrl_if.master)
//   pc             PC of the instruction in flight
//   running        high in every state except IDLE and HALT
//   halted         high in HALT
//   instret        retired-instruction count
//   cycles         clocks spent running
//
// Build option: define CORE_CTRL_PERF_EN to implement the instret/cycles
// counters; otherwise both outputs are tied to zero.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            halt_req,
  core_ctrl_if.master     stg,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            halted,
  output logic [31:0]     instret,
  output logic [63:0]     cycles
);

  ctrl_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] next_pc_q, next_pc_d;
  logic halt_q, halt_d;

  logic [NUM_STG-1:0] stage_en;
  logic [NUM_STG-1:0] stage_done;

  assign stage_done[STG_F] = stg.fetch_done;
  assign stage_done[STG_D] = stg.decode_done;
  assign stage_done[STG_E] = stg.exec_done;
  assign stage_done[STG_M] = stg.mem_done;
  assign stage_done[STG_W] = stg.wb_done;

  // Enables decode straight from the state register so a reset drops them at once.
  assign stg.fetch_en  = stage_en[STG_F];
  assign stg.decode_en = stage_en[STG_D];
  assign stg.exec_en   = stage_en[STG_E];
  assign stg.mem_en    = stage_en[STG_M];
  assign stg.wb_en     = stage_en[STG_W];

  assign running = (state_q != StIdle) && (state_q != StHalt);
  assign halted  = (state_q == StHalt);
  assign pc      = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      next_pc_q <= RESET_PC;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      halt_q    <= halt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    halt_d    = halt_q;
    stage_en  = '0;

    if (running && halt_req) begin
      halt_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d    = RESET_PC;
          // start together with halt_req runs exactly one instruction.
          halt_d  = halt_req;
          state_d = StF;
        end
      end
      // A done seen during the enable cycle is stale and deliberately ignored.
      StF: begin
        stage_en[STG_F] = 1'b1;
        state_d         = StFW;
      end
      StFW: if (stage_done[STG_F]) state_d = StD;
      StD: begin
        stage_en[STG_D] = 1'b1;
        state_d         = StDW;
      end
      StDW: if (stage_done[STG_D]) state_d = StE;
      StE: begin
        stage_en[STG_E] = 1'b1;
        state_d         = StEW;
      end
      StEW: begin
        if (stage_done[STG_E]) begin
          next_pc_d = stg.is_jump ? stg.jump_dest : pc_q + PC_W'(1);
          state_d   = StM;
        end
      end
      StM: begin
        stage_en[STG_M] = 1'b1;
        state_d         = StMW;
      end
      StMW: if (stage_done[STG_M]) state_d = StW;
      StW: begin
        stage_en[STG_W] = 1'b1;
        state_d         = StWW;
      end
      StWW: begin
        if (stage_done[STG_W]) begin
          pc_d    = next_pc_q;
          state_d = (halt_q || halt_req) ? StHalt : StF;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

`ifdef CORE_CTRL_PERF_EN
  logic [31:0] instret_q;
  logic [63:0] cycles_q;
  logic        retire;

  assign retire = (state_q == StWW) && stage_done[STG_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
      if (running) begin
        cycles_q <= cycles_q + 64'd1;
      end
    end
  end

  assign instret = instret_q;
  assign cycles  = cycles_q;
`else
  assign instret = '0;
  assign cycles  = '0;
`endif

endmodule
